uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. 2-flop input synchronizer,
//                3-sample majority vote per bit, optional even/odd parity,
//                registered one-cycle result pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] C_LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic                  rx_meta_q;
    logic                  rx_s_q;

    state_t                state_q,      state_d;
    logic [5:0]            edge_cnt_q,   edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic [5:0]            prescale_q,   prescale_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_typ_q,    par_typ_d;
    logic [1:0]            samp_q,       samp_d;
    logic                  par_bad_q,    par_bad_d;
    logic                  stop_bit_q,   stop_bit_d;
    logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q,    par_err_d;
    logic                  stp_err_q,    stp_err_d;
    logic                  busy_q,       busy_d;

    logic [5:0]            w_prescale_legal;
    logic [5:0]            w_half;
    logic [5:0]            w_samp_lo;
    logic [5:0]            w_samp_hi;
    logic [5:0]            w_bit_end;
    logic                  w_vote;

    // Bring the asynchronous serial line into the CLK domain (idle level = 1)
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Sample positions derived from the per-frame oversampling ratio
    assign w_half    = {1'b0, prescale_q[5:1]};
    assign w_samp_lo = w_half - 6'd1;
    assign w_samp_hi = w_half + 6'd1;
    assign w_bit_end = prescale_q - 6'd1;
    // Third sample is the live value; first two were captured earlier in the bit
    assign w_vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    // Unsupported ratios fall back to 8x oversampling
    always_comb begin
        case (Prescale)
            6'd8, 6'd16, 6'd32: w_prescale_legal = Prescale;
            default:            w_prescale_legal = 6'd8;
        endcase
    end

    // Next-state logic: bit timing, voting, shifting and end-of-frame evaluation
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        samp_d       = samp_q;
        par_bad_d    = par_bad_q;
        stop_bit_d   = stop_bit_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = (edge_cnt_q == w_bit_end) ? 6'd0 : edge_cnt_q + 6'd1;
            if (edge_cnt_q == w_samp_lo) samp_d[0] = rx_s_q;
            if (edge_cnt_q == w_half)    samp_d[1] = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = 6'd0;
                if (!rx_s_q) begin
                    // The detecting cycle is position 0 of the start bit, so the
                    // receiver stays phase-locked to back-to-back frames.
                    state_d    = ST_START;
                    edge_cnt_d = 6'd1;
                    prescale_d = w_prescale_legal;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            ST_START: begin
                if (edge_cnt_q == w_samp_hi && w_vote) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = 6'd0;
                end else if (edge_cnt_q == w_bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (edge_cnt_q == w_samp_hi) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = w_vote;
                end
                if (edge_cnt_q == w_bit_end) begin
                    if (bit_cnt_q == C_LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (edge_cnt_q == w_samp_hi) par_bad_d = ^shift_q ^ w_vote ^ par_typ_q;
                if (edge_cnt_q == w_bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (edge_cnt_q == w_samp_hi) stop_bit_d = w_vote;
                if (edge_cnt_q == w_bit_end) begin
                    state_d   = ST_IDLE;
                    par_err_d = par_bad_q;
                    stp_err_d = ~stop_bit_q;
                    if (!par_bad_q && stop_bit_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = 6'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prescale_q   <= 6'd8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= 2'b11;
            par_bad_q    <= 1'b0;
            stop_bit_q   <= 1'b1;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            samp_q       <= samp_d;
            par_bad_q    <= par_bad_d;
            stop_bit_q   <= stop_bit_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire
